sad_search_ctrl: RTL and testbench

Sequencer that drives the SAD datapath across a set of candidate block positions in operand memory B and reports the best match. It issues one `Go` pulse per candidate, with the B base address stepped by a fixed stride. It captures each `SAD_Out` on `Done`, tracks the minimum and its candidate index, and pulses its own `Done` when the search completes. It sits between the motion-estimation top level and the SAD unit; the A block base is fixed by the SAD unit.

---
 rtl/sad_pkg.sv | 17 +
 rtl/sad_search_ctrl_if.sv | 38 +++
 rtl/sad_min_tracker.sv | 34 +++
 rtl/sad_search_ctrl.sv | 131 +++++++++++++
 tb/tb_sad_search_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD motion-search blocks.
// Provides the search sequencer state type and the default widths of the
// SAD datapath (operand address, pixel data, SAD result).
package sad_pkg;

  localparam int A_WIDTH   = 15;
  localparam int D_WIDTH   = 8;
  localparam int SAD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } search_state_t;

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Signal bundle between the motion-estimation host, the search sequencer and
// the SAD unit.
//   Host side : Start, Abort, Base_B, Cand_Count -> ctrl; Busy, Done, Best_* <- ctrl
//   SAD side  : Sad_Go, Sad_Base_B -> SAD unit; Sad_Done, Sad_Value <- SAD unit
// slave  : view of the sequencer itself
// master : view of the environment (host + SAD unit)
interface sad_search_ctrl_if #(
  parameter int A_WIDTH   = sad_pkg::A_WIDTH,
  parameter int SAD_WIDTH = sad_pkg::SAD_WIDTH,
  parameter int IDX_WIDTH = 4
);

  logic                 Start;
  logic                 Abort;
  logic [A_WIDTH-1:0]   Base_B;
  logic [IDX_WIDTH:0]   Cand_Count;

  logic                 Sad_Go;
  logic [A_WIDTH-1:0]   Sad_Base_B;
  logic                 Sad_Done;
  logic [SAD_WIDTH-1:0] Sad_Value;

  logic                 Busy;
  logic                 Done;
  logic [SAD_WIDTH-1:0] Best_Sad;
  logic [IDX_WIDTH-1:0] Best_Idx;

  modport slave (
    input  Start, Abort, Base_B, Cand_Count, Sad_Done, Sad_Value,
    output Sad_Go, Sad_Base_B, Busy, Done, Best_Sad, Best_Idx
  );

  modport master (
    output Start, Abort, Base_B, Cand_Count, Sad_Done, Sad_Value,
    input  Sad_Go, Sad_Base_B, Busy, Done, Best_Sad, Best_Idx
  );

endinterface

// File: rtl/sad_min_tracker.sv
// Running-minimum register for SAD results.
//   Clk, Rst  : clock, synchronous active-high reset
//   clear     : restart tracking (minimum = all-ones, index = 0)
//   valid     : value/idx present a result to consider
//   value,idx : candidate SAD and its index
//   best_sad, best_idx : registered minimum and its index
// Strict less-than update, so on ties the earlier (lower) index is kept.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int SAD_WIDTH = sad_pkg::SAD_WIDTH,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [SAD_WIDTH-1:0] value,
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic [IDX_WIDTH-1:0] best_idx
);

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (valid && (value < best_sad)) begin
      best_sad <= value;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Candidate-search sequencer for the SAD unit.
// Issues one Sad_Go per candidate with the B base stepped by CAND_STRIDE,
// collects each Sad_Value on Sad_Done, keeps the minimum and its index, and
// pulses Done when every candidate has been evaluated.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : host handshake (Start/Abort/Base_B/Cand_Count/Busy/Done/Best_*)
//              and SAD unit handshake (Sad_Go/Sad_Base_B/Sad_Done/Sad_Value)
// All outputs are registered; Sad_Done never reaches Sad_Go combinationally.
module sad_search_ctrl #(
  parameter int A_WIDTH     = sad_pkg::A_WIDTH,
  parameter int SAD_WIDTH   = sad_pkg::SAD_WIDTH,
  parameter int IDX_WIDTH   = 4,
  parameter int CAND_STRIDE = 256
) (
  input  logic             Clk,
  input  logic             Rst,
  sad_search_ctrl_if.slave bus
);

  import sad_pkg::*;

  localparam logic [A_WIDTH-1:0] STRIDE = A_WIDTH'(CAND_STRIDE);

  search_state_t        state;
  logic [IDX_WIDTH:0]   idx;
  logic [IDX_WIDTH:0]   idx_next;
  logic [IDX_WIDTH:0]   count;
  logic [A_WIDTH-1:0]   base_b;
  logic                 go;
  logic                 busy;
  logic                 done;
  logic                 clear;
  logic                 valid;
  logic [SAD_WIDTH-1:0] best_sad;
  logic [IDX_WIDTH-1:0] best_idx;

  always_comb begin
    idx_next = idx + (IDX_WIDTH + 1)'(1);
    clear    = (state == IDLE) && bus.Start;
    // Abort wins over a same-cycle Sad_Done: that result is dropped.
    valid    = (state == WAIT) && bus.Sad_Done && !bus.Abort;
  end

  // base_b doubles as the address accumulator: loaded with Base_B on Start,
  // advanced by one stride on each following ISSUE, held through WAIT.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      idx    <= '0;
      count  <= '0;
      base_b <= '0;
      go     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      go   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            base_b <= bus.Base_B;
            count  <= bus.Cand_Count;
            idx    <= '0;
            busy   <= 1'b1;
            if (bus.Cand_Count == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              go    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.Abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.Abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.Sad_Done) begin
            idx <= idx_next;
            if (idx_next == count) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state  <= ISSUE;
              go     <= 1'b1;
              base_b <= base_b + STRIDE;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sad_min_tracker #(
    .SAD_WIDTH (SAD_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_min_tracker (
    .Clk      (Clk),
    .Rst      (Rst),
    .clear    (clear),
    .valid    (valid),
    .value    (bus.Sad_Value),
    .idx      (idx[IDX_WIDTH-1:0]),
    .best_sad (best_sad),
    .best_idx (best_idx)
  );

  assign bus.Sad_Go     = go;
  assign bus.Sad_Base_B = base_b;
  assign bus.Busy       = busy;
  assign bus.Done       = done;
  assign bus.Best_Sad   = best_sad;
  assign bus.Best_Idx   = best_idx;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed + randomized bench for sad_search_ctrl. The SAD unit is played by
// the stimulus itself, returning Sad_Done L cycles after each Sad_Go.
module tb_sad_search_ctrl;

  localparam int AW     = 15;
  localparam int SW     = 32;
  localparam int IW     = 4;
  localparam int STRIDE = 256;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  sad_search_ctrl_if #(.A_WIDTH(AW), .SAD_WIDTH(SW), .IDX_WIDTH(IW)) bus ();

  sad_search_ctrl #(
    .A_WIDTH     (AW),
    .SAD_WIDTH   (SW),
    .IDX_WIDTH   (IW),
    .CAND_STRIDE (STRIDE)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [SW-1:0] vals [16];

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: best is the smallest value seen (all-ones if none beat it),
  // reported at the first index holding that value.
  task automatic model(input int n, output logic [SW-1:0] bs, output logic [IW-1:0] bi);
    bit found;
    bs = '1;
    bi = '0;
    found = 1'b0;
    for (int i = 0; i < n; i++)
      if (vals[i] < bs) bs = vals[i];
    for (int i = 0; i < n; i++)
      if (!found && vals[i] == bs) begin
        bi = IW'(i);
        found = 1'b1;
      end
  endtask

  task automatic start(input logic [AW-1:0] base, input int n);
    bus.Start      = 1'b1;
    bus.Base_B     = base;
    bus.Cand_Count = 5'(n);
    tick();
    bus.Start      = 1'b0;
    bus.Base_B     = AW'($urandom);
    bus.Cand_Count = 5'($urandom);
  endtask

  // Entered in the ISSUE cycle of candidate i; returns after the edge that
  // consumes Sad_Done.
  task automatic do_cand(input int i, input logic [AW-1:0] base, input int lat,
                         input logic [SW-1:0] v, input bit abort_on_done,
                         input bit spur, input bit restart);
    logic [AW-1:0] a;
    a = base + AW'(i * STRIDE);
    chk("go_issue", bus.Sad_Go, 1);
    chk("addr_issue", bus.Sad_Base_B, a);
    chk("busy_issue", bus.Busy, 1);
    if (spur) begin
      bus.Sad_Done  = 1'b1;
      bus.Sad_Value = '0;
    end
    if (restart) begin
      bus.Start      = 1'b1;
      bus.Cand_Count = 5'd1;
      bus.Base_B     = '0;
    end
    tick();
    bus.Sad_Done = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      chk("go_wait", bus.Sad_Go, 0);
      chk("addr_wait", bus.Sad_Base_B, a);
      if (k == lat) begin
        bus.Sad_Done  = 1'b1;
        bus.Sad_Value = v;
        bus.Abort     = abort_on_done;
      end
      tick();
      bus.Sad_Done  = 1'b0;
      bus.Abort     = 1'b0;
      bus.Sad_Value = SW'($urandom);
    end
    bus.Start = 1'b0;
  endtask

  task automatic run_full(input logic [AW-1:0] base, input int n, input int lat,
                          input int spur_at, input int restart_at);
    int c1;
    logic [SW-1:0] bs;
    logic [IW-1:0] bi;
    start(base, n);
    c1 = cyc;
    for (int i = 0; i < n; i++)
      do_cand(i, base, lat, vals[i], 1'b0, i == spur_at, i == restart_at);
    model(n, bs, bi);
    chk("done_pulse", bus.Done, 1);
    chk("busy_finish", bus.Busy, 1);
    chk("go_finish", bus.Sad_Go, 0);
    chk("latency", cyc - c1 + 1, n * (1 + lat) + 1);
    chk("best_sad", bus.Best_Sad, bs);
    chk("best_idx", bus.Best_Idx, bi);
    tick();
    chk("done_low", bus.Done, 0);
    chk("busy_low", bus.Busy, 0);
    chk("best_sad_hold", bus.Best_Sad, bs);
    chk("best_idx_hold", bus.Best_Idx, bi);
  endtask

  initial begin
    logic [SW-1:0] bs;
    logic [IW-1:0] bi;
    int n;

    bus.Start      = 1'b0;
    bus.Abort      = 1'b0;
    bus.Base_B     = '0;
    bus.Cand_Count = '0;
    bus.Sad_Done   = 1'b0;
    bus.Sad_Value  = '0;

    // Reset state
    tick();
    tick();
    Rst = 1'b0;
    chk("rst_go", bus.Sad_Go, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_best_sad", bus.Best_Sad, 32'hFFFF_FFFF);
    chk("rst_best_idx", bus.Best_Idx, 0);
    chk("rst_addr", bus.Sad_Base_B, 0);

    // Basic search: 9,4,7,4 with L=3, tie keeps index 1, Done after 17 cycles
    vals[0] = 9; vals[1] = 4; vals[2] = 7; vals[3] = 4;
    run_full(15'h0100, 4, 3, -1, -1);
    chk("basic_sad", bus.Best_Sad, 4);
    chk("basic_idx", bus.Best_Idx, 1);

    // Spurious Sad_Done in IDLE
    bus.Sad_Done  = 1'b1;
    bus.Sad_Value = '0;
    tick();
    bus.Sad_Done  = 1'b0;
    chk("spur_idle_busy", bus.Busy, 0);
    chk("spur_idle_go", bus.Sad_Go, 0);
    chk("spur_idle_sad", bus.Best_Sad, 4);

    // Zero count: Done next cycle, Best_* cleared
    run_full(15'h0040, 0, 1, -1, -1);
    chk("zero_sad", bus.Best_Sad, 32'hFFFF_FFFF);
    chk("zero_go", bus.Sad_Go, 0);

    // Address wrap
    vals[0] = 100; vals[1] = 50; vals[2] = 75;
    run_full(15'h7F00, 3, 2, -1, -1);

    // Spurious Sad_Done in ISSUE of candidate 1, Start re-asserted in candidate 2
    vals[0] = 30; vals[1] = 20; vals[2] = 25; vals[3] = 40;
    run_full(15'h0800, 4, 2, 1, 2);

    // Abort in WAIT of candidate 2 with simultaneous Sad_Done=1, value 1
    vals[0] = 9; vals[1] = 6;
    start(15'h0200, 4);
    do_cand(0, 15'h0200, 2, vals[0], 1'b0, 1'b0, 1'b0);
    do_cand(1, 15'h0200, 2, vals[1], 1'b0, 1'b0, 1'b0);
    do_cand(2, 15'h0200, 2, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("abort_busy", bus.Busy, 0);
    chk("abort_done", bus.Done, 0);
    chk("abort_go", bus.Sad_Go, 0);
    chk("abort_sad", bus.Best_Sad, 6);
    chk("abort_idx", bus.Best_Idx, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_quiet_done", bus.Done, 0);
      chk("abort_quiet_go", bus.Sad_Go, 0);
    end

    // Abort in ISSUE
    start(15'h0300, 3);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    chk("abort_issue_busy", bus.Busy, 0);
    chk("abort_issue_go", bus.Sad_Go, 0);
    tick();
    chk("abort_issue_go2", bus.Sad_Go, 0);
    chk("abort_issue_done", bus.Done, 0);

    // Reset mid-WAIT after one candidate has updated Best_Sad
    vals[0] = 5;
    start(15'h1234, 4);
    do_cand(0, 15'h1234, 2, vals[0], 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_sad", bus.Best_Sad, 5);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("mid_rst_go", bus.Sad_Go, 0);
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_sad", bus.Best_Sad, 32'hFFFF_FFFF);
    chk("mid_rst_idx", bus.Best_Idx, 0);
    chk("mid_rst_addr", bus.Sad_Base_B, 0);
    vals[0] = 8; vals[1] = 3; vals[2] = 3; vals[3] = 12; vals[4] = 2;
    run_full(15'h0010, 5, 1, -1, -1);

    // Randomized searches, first one at the full 16-candidate count
    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? 16 : int'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++)
        vals[i] = (r == 5) ? SW'($urandom) : SW'($urandom_range(0, 15));
      run_full(AW'($urandom), n, int'($urandom_range(1, 4)), -1, -1);
    end
    model(0, bs, bi);
    chk("model_empty_sad", {32'd0, bs} ^ {32'd0, bus.Best_Sad} ^ {32'd0, bus.Best_Sad}, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
